// File: rtl/alu_op_sequencer_if.sv
// Request/response bus of alu_op_sequencer.
// The master issues operations and consumes results; the slave is the sequencer.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_op;      // [4] = ALU mode, [3:0] = ALU select
    logic        req_cin;     // carry-in, active-high
    logic        req_wide;    // 1 = 32-bit two-pass, 0 = 16-bit single pass
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;    // carry-out, active-high

    modport master (
        output req_valid, req_a, req_b, req_op, req_cin, req_wide, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_cin, req_wide, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences 16/32-bit operations through an external combinational 16-bit ALU
// (top_alu_16). Each pass drives registered operands, waits SETTLE_CYCLES
// clocks and samples the ALU. Wide operations run a low pass then a high pass,
// chaining the raw active-low carry from one pass into the next.
// The final pass retires one clock after its sample, so rsp_valid rises
// SETTLE_CYCLES+1 clocks (narrow) or 2*SETTLE_CYCLES+1 clocks (wide) after
// the request is accepted.
// SETTLE_CYCLES must be at least 1.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_op_sequencer_if.slave         bus,
    output logic [15:0]               o_alu_a,
    output logic [15:0]               o_alu_b,
    output logic                      o_alu_mode,
    output logic [3:0]                o_alu_sel,
    output logic                      o_alu_cin_n,
    input  logic [15:0]               i_alu_result,
    input  logic                      i_alu_cout_n
);

    // Counter holds 0..SETTLE_CYCLES: sample at SETTLE_CYCLES-1, retire at SETTLE_CYCLES.
    localparam int               CNT_W      = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RETIRE = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ready;

    // Control strobes decoded from the current state.
    logic             w_accept;
    logic             w_cap_lo;
    logic             w_cap_hi;

    // Upper operand halves wait here until the high pass starts.
    logic [15:0]      r_a_hi;
    logic [15:0]      r_b_hi;
    logic             r_wide;

    // Captured result and raw (active-low) carry of the most recent pass.
    logic [31:0]      r_result;
    logic             r_cout_n;

    // Next-state, counter and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_cap_lo    = 1'b0;
        w_cap_hi    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LO;
                    w_cnt_nxt   = '0;
                end
            end

            LO: begin
                if (r_cnt == CNT_SAMPLE) begin
                    w_cap_lo = 1'b1;
                end
                if ((r_cnt == CNT_SAMPLE) && r_wide) begin
                    w_state_nxt = HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_RETIRE) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            HI: begin
                if (r_cnt == CNT_SAMPLE) begin
                    w_cap_hi = 1'b1;
                end
                if (r_cnt == CNT_RETIRE) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, settle counter and registered request-ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Ready is registered so it stays low through reset and rises on the first edge after it.
            r_ready <= (w_state_nxt == IDLE);
        end
    end

    // Request capture, ALU drive registers and per-pass result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_hi      <= '0;
            r_b_hi      <= '0;
            r_wide      <= 1'b0;
            r_result    <= '0;
            r_cout_n    <= 1'b1;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_mode  <= 1'b0;
            o_alu_sel   <= '0;
            o_alu_cin_n <= 1'b1;
        end else begin
            if (w_accept) begin
                // Low-pass drive is loaded on the acceptance edge and held for the whole LO window.
                r_a_hi      <= bus.req_a[31:16];
                r_b_hi      <= bus.req_b[31:16];
                r_wide      <= bus.req_wide;
                o_alu_a     <= bus.req_a[15:0];
                o_alu_b     <= bus.req_b[15:0];
                o_alu_mode  <= bus.req_op[4];
                o_alu_sel   <= bus.req_op[3:0];
                o_alu_cin_n <= ~bus.req_cin;
                // Clearing here leaves the upper half zero for narrow operations.
                r_result    <= '0;
                r_cout_n    <= 1'b1;
            end

            if (w_cap_lo) begin
                r_result[15:0] <= i_alu_result;
                r_cout_n       <= i_alu_cout_n;
                if (r_wide) begin
                    // High-pass drive; the raw low-pass carry feeds straight back in.
                    o_alu_a     <= r_a_hi;
                    o_alu_b     <= r_b_hi;
                    o_alu_cin_n <= i_alu_cout_n;
                end
            end

            if (w_cap_hi) begin
                r_result[31:16] <= i_alu_result;
                r_cout_n        <= i_alu_cout_n;
            end
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.rsp_result = r_result;
    assign bus.rsp_cout   = ~r_cout_n;

    // Response must not move while the consumer stalls it.
    property p_rsp_stable;
        @(posedge clk) disable iff (rst)
            (bus.rsp_valid && !bus.rsp_ready) |=>
                (bus.rsp_valid && $stable(bus.rsp_result) && $stable(bus.rsp_cout));
    endproperty
    a_rsp_stable: assert property (p_rsp_stable);

    // ALU drive only changes on acceptance or on the low-to-high pass switch.
    property p_drive_stable;
        @(posedge clk) disable iff (rst)
            !(w_accept || (w_cap_lo && r_wide)) |=>
                $stable({o_alu_a, o_alu_b, o_alu_mode, o_alu_sel, o_alu_cin_n});
    endproperty
    a_drive_stable: assert property (p_drive_stable);

    // A request can only be taken while nothing is in flight.
    property p_ready_idle;
        @(posedge clk) disable iff (rst)
            bus.req_ready |-> (r_state == IDLE) && !bus.rsp_valid;
    endproperty
    a_ready_idle: assert property (p_ready_idle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 16-bit ALU
// (active-low carries) and a 32-bit reference model feeding a scoreboard.
module tb_alu_op_sequencer;

    localparam int S = 2;

    localparam logic [3:0] SEL_ADD = 4'b1001;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_XOR = 4'b0110;
    localparam logic [3:0] SEL_AND = 4'b1011;
    localparam logic [3:0] SEL_OR  = 4'b1110;

    localparam logic [4:0] ADD_OP = {1'b0, SEL_ADD};
    localparam logic [4:0] SUB_OP = {1'b0, SEL_SUB};
    localparam logic [4:0] XOR_OP = {1'b1, SEL_XOR};
    localparam logic [4:0] AND_OP = {1'b1, SEL_AND};
    localparam logic [4:0] OR_OP  = {1'b1, SEL_OR};

    typedef struct packed {
        logic [31:0] result;
        logic        cout;
        logic [15:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_op_sequencer_if bus ();

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_mode;
    logic [3:0]  alu_sel;
    logic        alu_cin_n;
    logic [15:0] alu_result;
    logic        alu_cout_n;
    logic [16:0] alu_sum;

    alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_mode   (alu_mode),
        .o_alu_sel    (alu_sel),
        .o_alu_cin_n  (alu_cin_n),
        .i_alu_result (alu_result),
        .i_alu_cout_n (alu_cout_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 16-bit ALU: active-low carry in/out; logic mode passes the carry through.
    always_comb begin
        alu_result = 16'h0000;
        alu_cout_n = 1'b1;
        alu_sum    = 17'h0;
        if (alu_mode) begin
            case (alu_sel)
                SEL_XOR: alu_result = alu_a ^ alu_b;
                SEL_AND: alu_result = alu_a & alu_b;
                SEL_OR:  alu_result = alu_a | alu_b;
                default: alu_result = alu_a;
            endcase
            alu_cout_n = alu_cin_n;
        end else begin
            case (alu_sel)
                SEL_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b}  + {16'h0, ~alu_cin_n};
                SEL_SUB: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, ~alu_cin_n};
                default: alu_sum = {1'b0, alu_a} + {16'h0, ~alu_cin_n};
            endcase
            alu_result = alu_sum[15:0];
            alu_cout_n = ~alu_sum[16];
        end
    end

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   accept_cyc = 0;

    // 32-bit reference result for a whole operation.
    function automatic exp_t golden(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic wide);
        exp_t        e;
        logic [31:0] am;
        logic [31:0] bm;
        logic [32:0] s;
        am = wide ? a : {16'h0, a[15:0]};
        bm = wide ? b : {16'h0, b[15:0]};
        s  = '0;
        e  = '0;
        if (op[4]) begin
            case (op[3:0])
                SEL_XOR: e.result = am ^ bm;
                SEL_AND: e.result = am & bm;
                SEL_OR:  e.result = am | bm;
                default: e.result = am;
            endcase
            e.cout = cin;
        end else begin
            if (op[3:0] == SEL_SUB) bm = wide ? ~b : {16'h0, ~b[15:0]};
            s        = {1'b0, am} + {1'b0, bm} + {32'h0, cin};
            e.result = wide ? s[31:0] : {16'h0, s[15:0]};
            e.cout   = wide ? s[32] : s[16];
        end
        e.lat = wide ? 16'(2 * S + 1) : 16'(S + 1);
        return e;
    endfunction

    // Present a request, push its expectation, and return at the negedge after acceptance.
    task automatic send_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic wide, output logic ok);
        int waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_wide  = wide;
        exp_q.push_back(golden(op, a, b, cin, wide));
        while (bus.req_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = (bus.req_ready === 1'b1);
        @(negedge clk);
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
        // Request lines are scrambled after acceptance; they must not matter any more.
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 5'($urandom);
        bus.req_cin   = 1'($urandom);
        bus.req_wide  = 1'($urandom);
    endtask

    // Wait (bounded) for rsp_valid at negedges; latency counted in clocks from acceptance.
    task automatic wait_rsp(output logic got, output int lat);
        int waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        got = (bus.rsp_valid === 1'b1);
        lat = cyc - accept_cyc;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_result !== 32'h0 || bus.rsp_cout !== 1'b0) begin n_err++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.rsp_result, bus.rsp_cout); end
        n_cmp++; if ({alu_a, alu_b, alu_sel, alu_mode} !== 37'h0) begin n_err++; $display("FAIL reset_alu_drive: got a=%h b=%h sel=%h mode=%b want zeros", alu_a, alu_b, alu_sel, alu_mode); end
        n_cmp++; if (alu_cin_n !== 1'b1) begin n_err++; $display("FAIL reset_alu_cin_n: got %b want 1", alu_cin_n); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL release_req_ready_before_edge: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL release_req_ready_after_edge: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_narrow_add();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(ADD_OP, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL narrow_add_accept: req_ready never rose"); end
        n_cmp++; if (alu_a !== 16'h00FF || alu_b !== 16'h0001 || alu_cin_n !== 1'b1 || {alu_mode, alu_sel} !== ADD_OP) begin
            n_err++; $display("FAIL narrow_add_lo_drive: got a=%h b=%h cin_n=%b op=%h want 00ff 0001 1 %h", alu_a, alu_b, alu_cin_n, {alu_mode, alu_sel}, ADD_OP);
        end
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL narrow_add_timeout: rsp_valid got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_result !== e.result || bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL narrow_add_result: got %h/%b want %h/%b", bus.rsp_result, bus.rsp_cout, e.result, e.cout); end
        n_cmp++; if (lat !== int'(e.lat)) begin n_err++; $display("FAIL narrow_add_latency: got %0d want %0d", lat, e.lat); end
        consume();
    endtask

    task automatic test_wide_add();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(ADD_OP, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wide_add_accept: req_ready never rose"); end
        // Last clock of the high pass.
        repeat (2 * S) @(negedge clk);
        n_cmp++; if (alu_a !== 16'hFFFF || alu_b !== 16'h0000 || alu_cin_n !== 1'b0) begin
            n_err++; $display("FAIL wide_add_hi_drive: got a=%h b=%h cin_n=%b want ffff 0000 0", alu_a, alu_b, alu_cin_n);
        end
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL wide_add_timeout: rsp_valid got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_result !== e.result || bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL wide_add_result: got %h/%b want %h/%b", bus.rsp_result, bus.rsp_cout, e.result, e.cout); end
        n_cmp++; if (lat !== int'(e.lat)) begin n_err++; $display("FAIL wide_add_latency: got %0d want %0d", lat, e.lat); end
        consume();
    endtask

    task automatic test_wide_xor();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(XOR_OP, 32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b1, 1'b1, ok);
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || got !== 1'b1) begin n_err++; $display("FAIL wide_xor_handshake: accept=%b rsp=%b want 1/1", ok, got); end
        n_cmp++; if (bus.rsp_result !== 32'h6042_6042) begin n_err++; $display("FAIL wide_xor_result: got %h want 60426042", bus.rsp_result); end
        n_cmp++; if (bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL wide_xor_carry_chain: got %b want %b", bus.rsp_cout, e.cout); end
        consume();
    endtask

    task automatic test_narrow_sub();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(SUB_OP, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, ok);
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || got !== 1'b1) begin n_err++; $display("FAIL narrow_sub_handshake: accept=%b rsp=%b want 1/1", ok, got); end
        n_cmp++; if (bus.rsp_result !== e.result || bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL narrow_sub_result: got %h/%b want %h/%b", bus.rsp_result, bus.rsp_cout, e.result, e.cout); end
        consume();
    endtask

    task automatic test_backpressure();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(ADD_OP, 32'hA5A5_FFFF, 32'h0000_0001, 1'b1, 1'b0, ok);
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || got !== 1'b1) begin n_err++; $display("FAIL bp_handshake: accept=%b rsp=%b want 1/1", ok, got); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_valid[%0d]: valid=%b ready=%b want 1/0", i, bus.rsp_valid, bus.req_ready); end
            n_cmp++; if (bus.rsp_result !== e.result || bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h/%b want %h/%b", i, bus.rsp_result, bus.rsp_cout, e.result, e.cout); end
        end
        consume();
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        logic got;
        int   lat;
        exp_t e;
        send_req(ADD_OP, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, ok);
        // Walk into the high pass; no response may appear on the way.
        for (int i = 0; i <= S; i++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_early_valid[%0d]: got %b want 0", i, bus.rsp_valid); end
            @(negedge clk);
        end
        n_cmp++; if (alu_a !== 16'hFFFF || alu_b !== 16'h0000) begin n_err++; $display("FAIL abort_in_hi: got a=%h b=%h want ffff 0000", alu_a, alu_b); end
        e = exp_q.pop_front();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL abort_handshake: valid=%b ready=%b want 0/0", bus.rsp_valid, bus.req_ready); end
        n_cmp++; if (bus.rsp_result !== 32'h0 || bus.rsp_cout !== 1'b0) begin n_err++; $display("FAIL abort_rsp_data: got %h/%b want 0/0", bus.rsp_result, bus.rsp_cout); end
        n_cmp++; if ({alu_a, alu_b, alu_sel, alu_mode, alu_cin_n} !== 38'h1) begin n_err++; $display("FAIL abort_alu_drive: got a=%h b=%h sel=%h mode=%b cin_n=%b", alu_a, alu_b, alu_sel, alu_mode, alu_cin_n); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_req(ADD_OP, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, ok);
        wait_rsp(got, lat);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || got !== 1'b1) begin n_err++; $display("FAIL post_abort_handshake: accept=%b rsp=%b want 1/1", ok, got); end
        n_cmp++; if (bus.rsp_result !== 32'h0000_0002 || bus.rsp_cout !== e.cout) begin n_err++; $display("FAIL post_abort_result: got %h/%b want 00000002/%b", bus.rsp_result, bus.rsp_cout, e.cout); end
        n_cmp++; if (lat !== int'(e.lat)) begin n_err++; $display("FAIL post_abort_latency: got %0d want %0d", lat, e.lat); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [5];
        logic       ok;
        logic       got;
        int         lat;
        exp_t       e;
        ops[0] = ADD_OP;
        ops[1] = SUB_OP;
        ops[2] = XOR_OP;
        ops[3] = AND_OP;
        ops[4] = OR_OP;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_req(ops[$urandom_range(0, 4)], $urandom, $urandom, 1'($urandom), 1'($urandom), ok);
            wait_rsp(got, lat);
            e = exp_q.pop_front();
            n_cmp++; if (ok !== 1'b1 || got !== 1'b1) begin n_err++; $display("FAIL b2b_handshake[%0d]: accept=%b rsp=%b want 1/1", i, ok, got); end
            n_cmp++; if (bus.rsp_result !== e.result || bus.rsp_cout !== e.cout || lat !== int'(e.lat)) begin
                n_err++; $display("FAIL b2b_result[%0d]: got %h/%b lat %0d want %h/%b lat %0d", i, bus.rsp_result, bus.rsp_cout, lat, e.result, e.cout, e.lat);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.req_cin   = 1'b0;
        bus.req_wide  = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_narrow_add();
        test_wide_add();
        test_wide_xor();
        test_narrow_sub();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-002 Parameter SHALL be SETTLE_CYCLES, default 2, minimum 1; it is the number of clocks the ALU inputs are held before its outputs are sampled.
REQ-003 Port clk, input, 1 bit: clock, rising-edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port req_valid, input, 1 bit: request present.
REQ-006 Port req_ready, output, 1 bit: block accepts a request.
REQ-007 Port req_a / req_b, input, 32 bits each: operands.
REQ-008 Port req_op, input, 5 bits: bit 4 is the mode and bits 3:0 are the select; opcode constants come from opcodes.vh.
REQ-009 Port req_cin, input, 1 bit: carry-in, active-high.
REQ-010 Port req_wide, input, 1 bit: 1 selects a 32-bit two-pass operation; 0 selects a 16-bit operation.
REQ-011 Port rsp_valid, input ready: rsp_valid is output, 1 bit (response present); rsp_ready is input, 1 bit (consumer accepts).
REQ-012 Port rsp_result, output, 32 bits: result. Port rsp_cout, output, 1 bit: carry-out, active-high.
REQ-013 ALU-side outputs SHALL be: alu_a[15:0], alu_b[15:0], alu_mode (1 bit), alu_sel[3:0], alu_cin_n (1 bit, active-low).
REQ-014 ALU-side inputs SHALL be: alu_result[15:0] and alu_cout_n (1 bit, active-low); these connect to top_alu_16.

Function
REQ-015 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-017 On acceptance, the block SHALL register a, b, op, cin and wide, and enter LO with the settle counter at 0.
REQ-018 In LO, the ALU drive SHALL be: alu_a = a[15:0], alu_b = b[15:0], alu_mode = op[4], alu_sel = op[3:0], alu_cin_n = ~cin.
REQ-019 All ALU-side outputs SHALL be registered and held stable for the whole settle window.
REQ-020 In LO, after SETTLE_CYCLES clocks, the block SHALL capture alu_result into result[15:0] and capture alu_cout_n.
REQ-021 After the LO capture, the block SHALL go to HI if wide is 1, otherwise to DONE with result[31:16] = 0.
REQ-022 In HI, the ALU drive SHALL be: alu_a = a[31:16], alu_b = b[31:16], same mode and select, alu_cin_n = the captured low-pass alu_cout_n (raw chaining, no inversion).
REQ-023 In HI, after SETTLE_CYCLES clocks, the block SHALL capture result[31:16] and the final alu_cout_n, then go to DONE.
REQ-024 In DONE, rsp_valid SHALL be 1, rsp_result SHALL be the captured result, and rsp_cout SHALL be ~(final alu_cout_n).
REQ-025 rsp_result and rsp_cout SHALL stay stable while rsp_valid is 1 and rsp_ready is 0.
REQ-026 DONE SHALL go to IDLE on the edge where rsp_ready is 1; no new request is accepted in that same cycle.
REQ-027 Latency from the acceptance edge to rsp_valid rising SHALL be SETTLE_CYCLES+1 clocks for narrow operations and 2*SETTLE_CYCLES+1 clocks for wide operations.
REQ-028 Logic-mode operations (op[4] = 1) SHALL still chain the carry and report rsp_cout exactly as sampled; the block SHALL NOT interpret the carry.
REQ-029 Changes on the req_* inputs outside the acceptance edge SHALL have no effect.
REQ-030 The settle counter SHALL be sized to count up to SETTLE_CYCLES and SHALL clear on every state entry.

Reset
REQ-031 While rst is 1, the state SHALL be IDLE and the counter 0.
REQ-032 While rst is 1, req_ready SHALL be 0, and it SHALL go to 1 on the first clock edge after rst deasserts.
REQ-033 While rst is 1, rsp_valid SHALL be 0, rsp_result SHALL be 0 and rsp_cout SHALL be 0.
REQ-034 While rst is 1, alu_a, alu_b and alu_sel SHALL be 0, alu_mode SHALL be 0 and alu_cin_n SHALL be 1.
REQ-035 Reset asserted mid-operation (LO, HI or DONE) SHALL abort the operation immediately with no response and SHALL clear all captured data.

Verification
REQ-036 Narrow ADD_OP, a = 0x00FF, b = 0x0001, cin = 0 -> rsp_result = 0x00000100, rsp_cout = 0, rsp_valid exactly SETTLE_CYCLES+1 clocks after acceptance.
REQ-037 Wide ADD_OP, a = 0xFFFFFFFF, b = 0x00000001, cin = 0 -> rsp_result = 0x00000000 and rsp_cout = 1; in HI, alu_cin_n = 0; latency = 2*SETTLE_CYCLES+1.
REQ-038 Wide XOR_OP, a = 0xDEADBEEF, b = 0xBEEFDEAD -> rsp_result = 0x60426042.
REQ-039 Narrow SUB_OP, a = 0x1234, b = 0x1234, cin = 1 -> rsp_result = 0x00000000; rsp_cout matches the ALU-reported carry inverted.
REQ-040 Backpressure: hold rsp_ready = 0 for 5 clocks in DONE -> rsp_valid, rsp_result and rsp_cout stay constant and req_ready stays 0; raise rsp_ready -> IDLE next edge and req_ready = 1.
REQ-041 Reset mid-operation: pulse rst during HI of a wide ADD_OP -> rsp_valid never asserts, all outputs return to reset values, and a following narrow ADD_OP 0x0001 + 0x0001 returns 0x00000002.
